// File: rtl/sysid_checker_pkg.sv
// rtl/sysid_checker_pkg.sv - shared types and constants for the sysid checker
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int TMO_W = 16;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// rtl/sysid_timeout_ctr.sv - loadable saturating stall counter with expiry flag
module sysid_timeout_ctr
  import sysid_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [TMO_W-1:0] load_val_i,
  output logic             expired_o
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] count_q, count_d;

  // Clear beats load beats increment; the count never wraps past all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads sysid words 0/1 and compares them to build-time values
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1642576140,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout_err
);

  state_e      state_q, state_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  logic        ctr_clr;
  logic        expired;
  logic        xfer_done;
  logic        stall;
  logic        timeout_hit;

  assign xfer_done   = avm_read_q & ~avm_waitrequest;
  assign stall       = avm_read_q & avm_waitrequest;
  assign timeout_hit = stall & expired;

  sysid_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr_i     (ctr_clr),
    .en_i      (stall),
    .load_i    (1'b0),
    .load_val_i('0),
    .expired_o (expired)
  );

  // Next-state, capture and compare; bus outputs are derived from the next state so they stay registered.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    match_d = match_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    ts_d    = ts_q;
    ctr_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (AUTO_START || start) begin
          state_d = RD_ID;
          ctr_clr = 1'b1;
        end
      end
      RD_ID: begin
        if (xfer_done) begin
          id_d    = avm_readdata;
          state_d = RD_TS;
          ctr_clr = 1'b1;
        end else if (timeout_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          match_d = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      RD_TS: begin
        if (xfer_done) begin
          ts_d    = avm_readdata;
          state_d = DONE;
          done_d  = 1'b1;
          match_d = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
          tmo_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          match_d = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RD_ID;
          ctr_clr = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d        = (state_d == RD_ID) || (state_d == RD_TS);
    avm_read_d    = busy_d;
    avm_address_d = (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  // State and output registers; reset drops the read strobe without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      match_q       <= 1'b0;
      tmo_q         <= 1'b0;
      id_q          <= '0;
      ts_q          <= '0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      match_q       <= match_d;
      tmo_q         <= tmo_d;
      id_q          <= id_d;
      ts_q          <= ts_d;
    end
  end

  assign avm_read        = avm_read_q;
  assign avm_address     = avm_address_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign match           = match_q;
  assign timeout_err     = tmo_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - directed self-checking bench for sysid_checker
module tb_sysid_checker;

  localparam logic [31:0] TS_OK  = 32'd1642576140;
  localparam logic [31:0] TS_BAD = 32'd1642576141;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;
  logic        busy;
  logic        done;
  logic        match;
  logic        timeout_err;

  logic [31:0] id_word;
  logic [31:0] ts_word;

  int vectors;
  int miscompares;

  sysid_checker #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(TS_OK),
    .TIMEOUT_CYCLES    (4),
    .AUTO_START        (1'b1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .id_value       (id_value),
    .timestamp_value(timestamp_value),
    .busy           (busy),
    .done           (done),
    .match          (match),
    .timeout_err    (timeout_err)
  );

  assign avm_readdata = avm_address ? ts_word : id_word;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"},  {31'd0, avm_read},    32'd0);
    check({tag, "_addr"},  {31'd0, avm_address}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},        32'd0);
    check({tag, "_done"},  {31'd0, done},        32'd0);
    check({tag, "_match"}, {31'd0, match},       32'd0);
    check({tag, "_tmo"},   {31'd0, timeout_err}, 32'd0);
    check({tag, "_id"},    id_value,             32'd0);
    check({tag, "_ts"},    timestamp_value,      32'd0);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset_n         = 1'b0;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    id_word         = 32'd0;
    ts_word         = TS_OK;

    // Reset state
    step();
    step();
    check_all_zero("rst");

    // Zero-wait auto-start check
    reset_n = 1'b1;
    step();
    check("a1_busy", {31'd0, busy},        32'd1);
    check("a1_read", {31'd0, avm_read},    32'd1);
    check("a1_addr", {31'd0, avm_address}, 32'd0);
    check("a1_done", {31'd0, done},        32'd0);
    step();
    check("a2_id",   id_value,             32'd0);
    check("a2_addr", {31'd0, avm_address}, 32'd1);
    check("a2_done", {31'd0, done},        32'd0);
    step();
    check("a3_done",  {31'd0, done},        32'd1);
    check("a3_match", {31'd0, match},       32'd1);
    check("a3_tmo",   {31'd0, timeout_err}, 32'd0);
    check("a3_ts",    timestamp_value,      TS_OK);
    check("a3_busy",  {31'd0, busy},        32'd0);
    check("a3_read",  {31'd0, avm_read},    32'd0);

    // Wrong timestamp
    ts_word = TS_BAD;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("b1_done", {31'd0, done}, 32'd0);
    check("b1_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    check("b3_done",  {31'd0, done},        32'd1);
    check("b3_match", {31'd0, match},       32'd0);
    check("b3_tmo",   {31'd0, timeout_err}, 32'd0);
    check("b3_ts",    timestamp_value,      TS_BAD);

    // Three stall cycles on each word
    ts_word         = TS_OK;
    start           = 1'b1;
    avm_waitrequest = 1'b1;
    step();
    start = 1'b0;
    check("c1_addr", {31'd0, avm_address}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("c_id_stall_addr", {31'd0, avm_address}, 32'd0);
      check("c_id_stall_read", {31'd0, avm_read},    32'd1);
    end
    avm_waitrequest = 1'b0;
    step();
    check("c5_id",   id_value,             32'd0);
    check("c5_addr", {31'd0, avm_address}, 32'd1);
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("c_ts_stall_addr", {31'd0, avm_address}, 32'd1);
      check("c_ts_stall_done", {31'd0, done},        32'd0);
    end
    avm_waitrequest = 1'b0;
    step();
    check("c9_done",  {31'd0, done},  32'd1);
    check("c9_match", {31'd0, match}, 32'd1);

    // Stuck slave with TIMEOUT_CYCLES=4; id register must keep its old value
    id_word         = 32'hDEAD_BEEF;
    avm_waitrequest = 1'b1;
    start           = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("d_wait_done", {31'd0, done}, 32'd0);
      check("d_wait_busy", {31'd0, busy}, 32'd1);
    end
    step();
    check("d6_done",  {31'd0, done},        32'd1);
    check("d6_tmo",   {31'd0, timeout_err}, 32'd1);
    check("d6_match", {31'd0, match},       32'd0);
    check("d6_read",  {31'd0, avm_read},    32'd0);
    check("d6_id",    id_value,             32'd0);
    id_word         = 32'd0;
    avm_waitrequest = 1'b0;

    // Restart from DONE, second start mid-RD_TS ignored
    start = 1'b1;
    step();
    start = 1'b0;
    check("e1_done",  {31'd0, done},        32'd0);
    check("e1_tmo",   {31'd0, timeout_err}, 32'd0);
    check("e1_match", {31'd0, match},       32'd0);
    step();
    avm_waitrequest = 1'b1;
    step();
    check("e3_addr", {31'd0, avm_address}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("e4_addr", {31'd0, avm_address}, 32'd1);
    check("e4_busy", {31'd0, busy},        32'd1);
    avm_waitrequest = 1'b0;
    step();
    check("e5_done",  {31'd0, done},  32'd1);
    check("e5_match", {31'd0, match}, 32'd1);
    step();
    step();
    check("e7_done", {31'd0, done}, 32'd1);
    check("e7_busy", {31'd0, busy}, 32'd0);
    check("e7_read", {31'd0, avm_read}, 32'd0);

    // Asynchronous reset during an RD_TS stall
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    avm_waitrequest = 1'b1;
    step();
    check("f_pre_read", {31'd0, avm_read}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("f_async");
    avm_waitrequest = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("f1_busy", {31'd0, busy}, 32'd1);
    step();
    step();
    check("f3_done",  {31'd0, done},   32'd1);
    check("f3_match", {31'd0, match},  32'd1);
    check("f3_ts",    timestamp_value, TS_OK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its `readdata`. After reset, or on request, it reads word 0 (system ID) and word 1 (build timestamp), latches both and compares them against build-time expected values. It raises a sticky pass/fail/timeout status for boot firmware or a board-level LED. This lets the hardware/software pairing be checked without involving the CPU.

## Interface
Parameters:
- `EXPECTED_ID`, default 32'd0: value required at word 0.
- `EXPECTED_TIMESTAMP`, default 32'd1642576140: value required at word 1.
- `TIMEOUT_CYCLES`, default 255: max consecutive stalled cycles per read, range 1..65535.
- `AUTO_START`, default 1: start a check automatically after reset.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle request to (re)run the check
- `avm_address`  out  1  word address to the sysid slave
- `avm_read`  out  1  read strobe
- `avm_readdata`  in  32  slave read data
- `avm_waitrequest`  in  1  slave stall
- `id_value`  out  32  latched word 0
- `timestamp_value`  out  32  latched word 1
- `busy`  out  1  check in progress
- `done`  out  1  check finished (sticky until next start)
- `match`  out  1  both words equal expected values; valid when `done`=1
- `timeout_err`  out  1  a read exceeded `TIMEOUT_CYCLES`; valid when `done`=1

## Operation
- States: IDLE, RD_ID, RD_TS, DONE.
- Reset values: state IDLE. All outputs are 0: `avm_read`, `avm_address`, `id_value`, `timestamp_value`, `busy`, `done`, `match`, `timeout_err`. Timeout counter is 0.
- IDLE -> RD_ID on the first edge after reset release when `AUTO_START`=1, otherwise when `start`=1.
- RD_ID drives `avm_address`=0 and `avm_read`=1. A transfer completes on an edge where `avm_read`=1 and `avm_waitrequest`=0. On that edge, `avm_readdata` -> `id_value` and the state moves to RD_TS.
- RD_TS drives `avm_address`=1 and `avm_read`=1. On completion, `avm_readdata` -> `timestamp_value` and the state moves to DONE.
- On DONE entry: `done`=1, `busy`=0, `avm_read`=0, `match`=(id==EXPECTED_ID)&&(ts==EXPECTED_TIMESTAMP), `timeout_err`=0.
- Timeout: a 16-bit counter clears on entry to RD_ID and RD_TS and increments on each edge with `avm_read`=1 and `avm_waitrequest`=1.
  - When the counter equals `TIMEOUT_CYCLES` and the slave is still stalling, the block goes to DONE with `timeout_err`=1 and `match`=0.
  - The aborted word's register keeps its previous value.
- `busy`=1 exactly in RD_ID and RD_TS.
- `start` in RD_ID or RD_TS is ignored.
- `start` in DONE moves to RD_ID and clears `done`, `match` and `timeout_err` on that edge. `id_value` and `timestamp_value` hold until overwritten.
- `start` in IDLE with `AUTO_START`=1 is not possible, because IDLE lasts one cycle.
- Reset asserted mid-read drops `avm_read` immediately (asynchronously) and returns all state and outputs to reset values.
- `avm_address` and `avm_read` are registered outputs with no combinational path from inputs. `avm_address` is held stable while `avm_read`=1 and `avm_waitrequest`=1.

## Timing
- Zero-wait slave with `AUTO_START`=1:
  - Edge 1 after reset release: enter RD_ID.
  - Edge 2: capture ID.
  - Edge 3: capture timestamp, `done`=1, `match` valid.
- Each stall cycle adds one cycle per word.
- Worst-case completion from entering RD_ID is 2*(TIMEOUT_CYCLES+1) cycles.
- `match` and `timeout_err` change only on DONE entry or on a restart.

## Structure
- Shared package `sysid_checker_pkg` holds:
  - state enum: IDLE, RD_ID, RD_TS, DONE;
  - word-address constants: SYSID_ADDR_ID=0, SYSID_ADDR_TS=1;
  - timeout counter width constant: 16.
- One sub-module, `sysid_timeout_ctr`. It is a loadable saturating counter with clear, enable and an `expired` flag; `TIMEOUT_CYCLES` is a parameter.
- FSM, capture registers and compare logic live in the top.

## Test plan
- Reset release, `AUTO_START`=1, slave returns 0 / 1642576140 with no wait -> `done`=1 on the 3rd edge, `match`=1, `id_value`=0, `timestamp_value`=1642576140.
- Slave returns word 1 = 1642576141 -> `done`=1, `match`=0, `timeout_err`=0, `timestamp_value`=1642576141.
- `avm_waitrequest` held 3 cycles on each read -> `avm_address` stable during stalls, `done` on the 9th edge, `match`=1.
- `TIMEOUT_CYCLES`=4, `avm_waitrequest` stuck high -> DONE 5 edges into RD_ID, `timeout_err`=1, `match`=0, `avm_read`=0.
- `start` pulse in DONE, then a second pulse mid-RD_TS -> one restart only, `done` cleared on the restart edge, single re-check completes with `match`=1.
- `reset_n` low during RD_TS stall -> `avm_read` and all outputs 0 without a clock edge. After release with `AUTO_START`=1, a full check reruns and passes.
